// File: rtl/wb_pwm_io_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pwm_io_if
//  Description : Wishbone classic slave bundle for the PWM / button peripheral.
//                The slave modport faces the peripheral and the master modport
//                faces the crossbar or the bench.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_pwm_io_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_we_i;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_pwm_io.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pwm_io
//  Description : Wishbone slave with NUM_LEDS glitch-free PWM outputs and
//                NUM_BUTTONS debounced inputs with edge-mode interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_pwm_io #(
  parameter int AW              = 16,
  parameter int DW              = 32,
  parameter int NUM_LEDS        = 3,
  parameter int NUM_BUTTONS     = 2,
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 16000
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_reset_ni,
  wb_pwm_io_if.slave             wb,
  output logic [NUM_LEDS-1:0]    leds,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                   irq
);

  localparam int                c_DBW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_DBW-1:0]  c_DB_LAST   = c_DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] c_CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [5:0] c_A_PRESCALE = 6'h00;
  localparam logic [5:0] c_A_BTN      = 6'h01;
  localparam logic [5:0] c_A_STATUS   = 6'h02;
  localparam logic [5:0] c_A_ENABLE   = 6'h03;
  localparam logic [5:0] c_A_MODE     = 6'h04;

  // Bus-side registers
  logic                     r_ack;
  logic [DW-1:0]            r_dat;
  logic                     r_irq;
  logic [15:0]              r_prescale;
  logic [NUM_BUTTONS-1:0]   r_status;
  logic [NUM_BUTTONS-1:0]   r_enable;
  logic [2*NUM_BUTTONS-1:0] r_mode;
  logic [PWM_BITS-1:0]      r_duty [NUM_LEDS];

  // PWM timebase
  logic [15:0]              r_pre_cnt;
  logic [PWM_BITS-1:0]      r_cnt;

  // Combinational helpers
  logic                     w_req, w_wr, w_tick, w_wrap, w_pre_wr, w_duty_hit;
  logic [5:0]               w_adr;
  logic [3:0]               w_duty_idx;
  logic [DW-1:0]            w_mask, w_wbits, w_rdata;
  logic [DW-1:0]            w_new_prescale, w_new_enable, w_new_mode, w_new_duty;
  logic [PWM_BITS-1:0]      w_duty_old;
  logic [NUM_BUTTONS-1:0]   w_db, w_set, w_clr;

  // A new request is only taken when no ack is outstanding, so a held strobe
  // is served on alternate cycles.
  assign w_req      = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr       = w_req & wb.wb_we_i;
  assign w_adr      = wb.wb_adr_i[5:0];
  assign w_duty_idx = w_adr[3:0];
  assign w_duty_hit = (w_adr[5:4] == 2'b01) && ({1'b0, w_duty_idx} < 5'(NUM_LEDS));
  assign w_pre_wr   = w_wr && (w_adr == c_A_PRESCALE);
  assign w_wbits    = wb.wb_dat_i & w_mask;
  assign w_clr      = (w_wr && (w_adr == c_A_STATUS)) ? w_wbits[NUM_BUTTONS-1:0] : '0;

  for (genvar b = 0; b < DW / 8; b++) begin : g_sel
    assign w_mask[8*b +: 8] = {8{wb.wb_sel_i[b]}};
  end

  // Read mux and byte-merged write values for the addressed register
  always_comb begin
    w_rdata    = '0;
    w_duty_old = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (w_duty_idx == 4'(i)) w_duty_old = r_duty[i];
    end
    w_new_prescale = (DW'(r_prescale) & ~w_mask) | w_wbits;
    w_new_enable   = (DW'(r_enable)   & ~w_mask) | w_wbits;
    w_new_mode     = (DW'(r_mode)     & ~w_mask) | w_wbits;
    w_new_duty     = (DW'(w_duty_old) & ~w_mask) | w_wbits;
    case (w_adr)
      c_A_PRESCALE: w_rdata[15:0]              = r_prescale;
      c_A_BTN:      w_rdata[NUM_BUTTONS-1:0]   = w_db;
      c_A_STATUS:   w_rdata[NUM_BUTTONS-1:0]   = r_status;
      c_A_ENABLE:   w_rdata[NUM_BUTTONS-1:0]   = r_enable;
      c_A_MODE:     w_rdata[2*NUM_BUTTONS-1:0] = r_mode;
      default:      if (w_duty_hit) w_rdata[PWM_BITS-1:0] = w_duty_old;
    endcase
  end

  // Bus handshake, register writes, interrupt status and the irq line
  always_ff @(posedge wb_clk_i) begin
    if (!wb_reset_ni) begin
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_irq      <= 1'b0;
      r_prescale <= '0;
      r_status   <= '0;
      r_enable   <= '0;
      r_mode     <= '0;
      for (int i = 0; i < NUM_LEDS; i++) r_duty[i] <= '0;
    end else begin
      r_ack    <= w_req;
      r_dat    <= (w_req && !wb.wb_we_i) ? w_rdata : '0;
      r_irq    <= |(r_status & r_enable);
      // A new edge in the same cycle as a W1C keeps the bit set.
      r_status <= (r_status & ~w_clr) | w_set;
      if (w_wr) begin
        case (w_adr)
          c_A_PRESCALE: r_prescale <= w_new_prescale[15:0];
          c_A_ENABLE:   r_enable   <= w_new_enable[NUM_BUTTONS-1:0];
          c_A_MODE:     r_mode     <= w_new_mode[2*NUM_BUTTONS-1:0];
          default: begin
            for (int i = 0; i < NUM_LEDS; i++) begin
              if (w_duty_hit && (w_duty_idx == 4'(i))) r_duty[i] <= w_new_duty[PWM_BITS-1:0];
            end
          end
        endcase
      end
    end
  end

  assign w_tick = (r_pre_cnt == r_prescale);
  assign w_wrap = w_tick && (r_cnt == c_CNT_LAST);

  // Prescaler and PWM period counter; the period is 2^PWM_BITS-1 ticks
  always_ff @(posedge wb_clk_i) begin
    if (!wb_reset_ni) begin
      r_pre_cnt <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_pre_wr || w_tick) r_pre_cnt <= '0;
      else                    r_pre_cnt <= r_pre_cnt + 16'd1;
      if (w_tick) r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
    logic [PWM_BITS-1:0] r_active;
    logic                r_led;

    // Duty is latched only at the period boundary so a period is never cut short
    always_ff @(posedge wb_clk_i) begin
      if (!wb_reset_ni) begin
        r_active <= '0;
        r_led    <= 1'b0;
      end else begin
        if (w_wrap) r_active <= r_duty[i];
        r_led <= (r_cnt < r_active);
      end
    end

    assign leds[i] = r_led;
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    logic             r_sync1, r_sync2, r_db;
    logic [c_DBW-1:0] r_dbc;
    logic             w_toggle;

    assign w_toggle = (r_sync2 != r_db) && (r_dbc == c_DB_LAST);
    assign w_set[i] = w_toggle && (r_sync2 ? r_mode[2*i] : r_mode[2*i+1]);
    assign w_db[i]  = r_db;

    // Synchronise, then accept a new level once it has been stable long enough
    always_ff @(posedge wb_clk_i) begin
      if (!wb_reset_ni) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_db    <= 1'b0;
        r_dbc   <= '0;
      end else begin
        r_sync1 <= buttons[i];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_db) begin
          r_dbc <= '0;
        end else if (r_dbc == c_DB_LAST) begin
          r_db  <= ~r_db;
          r_dbc <= '0;
        end else begin
          r_dbc <= r_dbc + 1'b1;
        end
      end
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wb_pwm_io.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_pwm_io
//  Description : Self-checking bench for wb_pwm_io: register table, PWM duty
//                windows, debounce timing and edge-mode interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_pwm_io;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] leds;
  logic [1:0] buttons;
  logic       irq;
  logic [31:0] rd;

  always #5 clk = ~clk;

  wb_pwm_io_if #(.AW(16), .DW(32)) bus_if ();

  wb_pwm_io #(
    .AW(16), .DW(32), .NUM_LEDS(3), .NUM_BUTTONS(2),
    .PWM_BITS(8), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .wb_clk_i   (clk),
    .wb_reset_ni(rst_n),
    .wb         (bus_if.slave),
    .leds       (leds),
    .buttons    (buttons),
    .irq        (irq)
  );

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic xfer(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata);
    int lat = 0;
    bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1; bus_if.wb_we_i = we;
    bus_if.wb_adr_i = adr;  bus_if.wb_dat_i = dat;  bus_if.wb_sel_i = sel;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus_if.wb_ack_o !== 1'b1 && lat < 8);
    rdata = bus_if.wb_dat_o;
    bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
    check("ack_latency", 32'(lat), 32'd1);
    cycles(1);
    check("ack_one_cycle", {31'd0, bus_if.wb_ack_o}, 32'd0);
  endtask

  task automatic wr(input logic [15:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    xfer(1'b1, adr, dat, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, adr, 32'd0, 4'hF, r);
    check(name, r, exp);
  endtask

  // Clocks from a held-high input change until irq is first seen high
  task automatic irq_latency(input string name, input int exp);
    int first = -1;
    for (int k = 1; k <= 15; k++) begin
      cycles(1);
      if (irq === 1'b1 && first < 0) first = k;
    end
    check(name, 32'(first), 32'(exp));
  endtask

  // Length of the next full high pulse on one LED
  task automatic next_run(input int ch, output int run);
    logic prev;
    int   found = 0;
    run = 0;
    for (int k = 0; k < 600 && found == 0; k++) begin
      prev = leds[ch];
      cycles(1);
      if (!prev && leds[ch]) found = 1;
    end
    for (int k = 0; k < 600 && found == 1; k++) begin
      if (!leds[ch]) found = 2;
      else begin
        run++;
        cycles(1);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   run;
    int   cnt [3];
    int   pre;
    int   duty [3];
    int   len;
    logic [3:0] pat;

    rst_n = 1'b0; buttons = '0;
    bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
    bus_if.wb_adr_i = '0;   bus_if.wb_dat_i = '0;   bus_if.wb_sel_i = '0;
    cycles(3);
    check("reset_leds", {29'd0, leds}, 32'd0);
    check("reset_irq",  {31'd0, irq}, 32'd0);
    check("reset_ack",  {31'd0, bus_if.wb_ack_o}, 32'd0);
    check("reset_dat",  bus_if.wb_dat_o, 32'd0);
    rst_n = 1'b1;
    cycles(1);

    // Held strobe: acked on alternate cycles
    bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1; bus_if.wb_adr_i = 16'h0;
    for (int k = 0; k < 4; k++) begin
      cycles(1);
      pat[3-k] = bus_if.wb_ack_o;
    end
    bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0;
    check("back_to_back_ack", {28'd0, pat}, 32'h0000_000A);
    cycles(1);

    // Register table
    add(0, 16'h00, 0, 4'hF, 0);  add(0, 16'h01, 0, 4'hF, 0);
    add(0, 16'h02, 0, 4'hF, 0);  add(0, 16'h03, 0, 4'hF, 0);
    add(0, 16'h04, 0, 4'hF, 0);  add(0, 16'h10, 0, 4'hF, 0);
    add(0, 16'h11, 0, 4'hF, 0);  add(0, 16'h12, 0, 4'hF, 0);
    add(0, 16'h13, 0, 4'hF, 0);  add(0, 16'h3F, 0, 4'hF, 0);
    add(1, 16'h00, 32'h1234, 4'hF, 0);        add(0, 16'h00, 0, 4'hF, 32'h1234);
    add(1, 16'h00, 32'hABCD, 4'b0010, 0);     add(0, 16'h00, 0, 4'hF, 32'hAB34);
    add(1, 16'h00, 32'hFFFF_0000, 4'hF, 0);   add(0, 16'h00, 0, 4'hF, 32'h0);
    add(1, 16'h11, 32'h1A5, 4'hF, 0);         add(0, 16'h11, 0, 4'hF, 32'hA5);
    add(1, 16'h12, 32'h77, 4'b1110, 0);       add(0, 16'h12, 0, 4'hF, 32'h0);
    add(1, 16'h13, 32'h55, 4'hF, 0);          add(0, 16'h13, 0, 4'hF, 32'h0);
    add(1, 16'h03, 32'hFFFF_FFFF, 4'hF, 0);   add(0, 16'h03, 0, 4'hF, 32'h3);
    add(1, 16'h04, 32'hFFFF_FFFF, 4'hF, 0);   add(0, 16'h04, 0, 4'hF, 32'hF);
    add(1, 16'h01, 32'hFF, 4'hF, 0);          add(0, 16'h01, 0, 4'hF, 32'h0);
    add(1, 16'h02, 32'hFF, 4'hF, 0);          add(0, 16'h02, 0, 4'hF, 32'h0);
    add(1, 16'h03, 0, 4'hF, 0);  add(1, 16'h04, 0, 4'hF, 0);
    add(1, 16'h11, 0, 4'hF, 0);  add(1, 16'h00, 0, 4'hF, 0);
    foreach (tbl[k]) begin
      xfer(tbl[k].we, tbl[k].adr, tbl[k].dat, tbl[k].sel, rd);
      if (!tbl[k].we) check($sformatf("tbl[%0d] adr 0x%0h", k, tbl[k].adr), rd, tbl[k].exp);
    end

    // PWM: high clocks in any full period equal duty*(PRESCALE+1)
    wr(16'h10, 64); wr(16'h11, 255); wr(16'h12, 0);
    cycles(520);
    cnt = '{0, 0, 0};
    for (int k = 0; k < 255; k++) begin
      cycles(1);
      for (int c = 0; c < 3; c++) cnt[c] += int'(leds[c]);
    end
    check("pwm_duty64",  32'(cnt[0]), 32'd64);
    check("pwm_duty255", 32'(cnt[1]), 32'd255);
    check("pwm_duty0",   32'(cnt[2]), 32'd0);

    // Mid-period duty change: current period keeps 200, next one uses 10
    wr(16'h11, 200);
    cycles(520);
    run = 0;
    begin
      logic prev;
      int   found = 0;
      for (int k = 0; k < 600 && found == 0; k++) begin
        prev = leds[1];
        cycles(1);
        if (!prev && leds[1]) found = 1;
      end
      check("pwm_rise_found", 32'(found), 32'd1);
      run = 1;
      for (int k = 1; k < 600 && found == 1; k++) begin
        if (k == 98) begin
          bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1; bus_if.wb_we_i = 1'b1;
          bus_if.wb_adr_i = 16'h11; bus_if.wb_dat_i = 32'd10; bus_if.wb_sel_i = 4'hF;
        end
        cycles(1);
        if (bus_if.wb_ack_o) begin
          bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
        end
        if (!leds[1]) found = 2;
        else run++;
      end
    end
    check("pwm_midchange_keep", 32'(run), 32'd200);
    next_run(1, run);
    check("pwm_midchange_next", 32'(run), 32'd10);

    // Randomised duty and prescale against duty*(P+1) high clocks per period
    for (int it = 0; it < 3; it++) begin
      pre = int'($urandom_range(0, 3));
      for (int c = 0; c < 3; c++) duty[c] = int'($urandom_range(0, 255));
      wr(16'h00, 32'(pre));
      for (int c = 0; c < 3; c++) wr(16'h10 + 16'(c), 32'(duty[c]));
      cycles(2 * 255 * (pre + 1) + 10);
      cnt = '{0, 0, 0};
      for (int k = 0; k < 255 * (pre + 1); k++) begin
        cycles(1);
        for (int c = 0; c < 3; c++) cnt[c] += int'(leds[c]);
      end
      for (int c = 0; c < 3; c++)
        check($sformatf("rand_pwm it%0d ch%0d p%0d d%0d", it, c, pre, duty[c]),
              32'(cnt[c]), 32'(duty[c] * (pre + 1)));
    end
    wr(16'h00, 0);

    // Debounce on button 0 with rising-edge interrupt
    wr(16'h04, 32'h1); wr(16'h03, 32'h1);
    buttons[0] = 1'b1; cycles(3); buttons[0] = 1'b0; cycles(12);
    rd_chk("glitch_btn_state", 16'h01, 32'h0);
    rd_chk("glitch_status",    16'h02, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'd0);
    buttons[0] = 1'b1;
    irq_latency("debounce_irq_latency", DEB + 3);
    rd_chk("btn_state_high", 16'h01, 32'h1);
    rd_chk("rise_status",    16'h02, 32'h1);
    wr(16'h02, 32'h1);
    check("w1c_irq_low", {31'd0, irq}, 32'd0);
    buttons[0] = 1'b0; cycles(10);
    rd_chk("release_no_rise", 16'h02, 32'h0);

    // W1C colliding with a new matching edge: set wins
    buttons[0] = 1'b1; cycles(10); buttons[0] = 1'b0; cycles(10);
    buttons[0] = 1'b1;
    cycles(DEB + 1);
    bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1; bus_if.wb_we_i = 1'b1;
    bus_if.wb_adr_i = 16'h02; bus_if.wb_dat_i = 32'h1; bus_if.wb_sel_i = 4'hF;
    cycles(1);
    check("collision_ack", {31'd0, bus_if.wb_ack_o}, 32'd1);
    bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
    cycles(1);
    rd_chk("collision_set_wins", 16'h02, 32'h1);
    check("collision_irq", {31'd0, irq}, 32'd1);
    wr(16'h02, 32'h1);
    buttons[0] = 1'b0; cycles(10);

    // Randomised pulse widths: accepted only when held for DEB clocks; irq masked
    wr(16'h03, 32'h0);
    for (int it = 0; it < 6; it++) begin
      len = int'($urandom_range(1, 7));
      buttons[0] = 1'b1; cycles(len); buttons[0] = 1'b0; cycles(DEB + 8);
      rd_chk($sformatf("rand_pulse it%0d len%0d", it, len), 16'h02, (len >= DEB) ? 32'h1 : 32'h0);
      check("rand_pulse_irq_masked", {31'd0, irq}, 32'd0);
      wr(16'h02, 32'h1);
    end

    // Falling-edge interrupt on button 1
    wr(16'h04, 32'h8); wr(16'h03, 32'h2);
    buttons[1] = 1'b1; cycles(15);
    check("press_no_irq", {31'd0, irq}, 32'd0);
    rd_chk("press_status", 16'h02, 32'h0);
    buttons[1] = 1'b0;
    irq_latency("fall_irq_latency", DEB + 3);
    rd_chk("fall_status", 16'h02, 32'h2);
    check("irq_held", {31'd0, irq}, 32'd1);
    wr(16'h02, 32'h2);
    check("fall_w1c_irq", {31'd0, irq}, 32'd0);

    // Reset asserted during a bus cycle: no ack, no commit
    wr(16'h00, 32'h55);
    bus_if.wb_cyc_i = 1'b1; bus_if.wb_stb_i = 1'b1; bus_if.wb_we_i = 1'b1;
    bus_if.wb_adr_i = 16'h00; bus_if.wb_dat_i = 32'h99; bus_if.wb_sel_i = 4'hF;
    rst_n = 1'b0;
    cycles(1);
    check("reset_mid_ack0", {31'd0, bus_if.wb_ack_o}, 32'd0);
    cycles(1);
    check("reset_mid_ack1", {31'd0, bus_if.wb_ack_o}, 32'd0);
    bus_if.wb_cyc_i = 1'b0; bus_if.wb_stb_i = 1'b0; bus_if.wb_we_i = 1'b0;
    rst_n = 1'b1;
    cycles(1);
    rd_chk("reset_mid_prescale", 16'h00, 32'h0);
    check("reset_mid_leds", {29'd0, leds}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
